// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: bus bundle between the fetch/memory stages, the unified
// memory and mem_arbiter.
//
// Request/ack handshake, identical on the I and D sides:
//   - The stage raises *_req and holds it, together with its address (and, on D,
//     we/be/wdata), stable until the cycle in which its *_ack is high.
//   - *_ack is a single-cycle pulse. On a read, the matching *_rdata is valid in
//     that cycle and holds until the next ack on the same side.
//   - During the ack cycle the stage may drop *_req or present a new request.
//   - i_ack and d_ack are never high together.
//
// Memory side: mem_en stays high for the whole access. mem_we/mem_be/mem_addr/
// mem_wdata are stable while mem_en is high. mem_rdata is sampled in the last
// cycle of the access.
//
// Modports:
//   slave  - the arbiter (serves requests, drives the memory)
//   master - the requesters and the memory model
interface mem_arbiter_if;
    logic        i_req;
    logic [31:0] i_addr;
    logic [31:0] i_rdata;
    logic        i_ack;

    logic        d_req;
    logic        d_we;
    logic [3:0]  d_be;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [31:0] d_rdata;
    logic        d_ack;

    logic        mem_en;
    logic        mem_we;
    logic [3:0]  mem_be;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    logic        grant_d;

    modport slave (
        input  i_req, i_addr, d_req, d_we, d_be, d_addr, d_wdata, mem_rdata,
        output i_rdata, i_ack, d_rdata, d_ack,
        output mem_en, mem_we, mem_be, mem_addr, mem_wdata, grant_d
    );

    modport master (
        output i_req, i_addr, d_req, d_we, d_be, d_addr, d_wdata, mem_rdata,
        input  i_rdata, i_ack, d_rdata, d_ack,
        input  mem_en, mem_we, mem_be, mem_addr, mem_wdata, grant_d
    );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port unified memory between the fetch stage
// (I) and the memory stage (D).
//
// Each access takes LAT memory cycles, followed by a one-cycle ack pulse and then
// one IDLE cycle in which the next access is arbitrated. D has fixed priority.
// After STARVE_MAX consecutive D grants made while I was waiting, the next
// contested grant goes to I.
//
// Ports:
//   clk       - rising-edge clock
//   reset     - asynchronous, active-low
//   bus       - mem_arbiter_if.slave (I/D request ports and memory port)
//   dbg_state - current FSM state (0 = IDLE, 1 = BUSY, 2 = DONE)
module mem_arbiter #(
    parameter int LAT        = 2,
    parameter int STARVE_MAX = 4,
    parameter int CW         = 3
) (
    input  logic         clk,
    input  logic         reset,
    mem_arbiter_if.slave bus,
    output logic [1:0]   dbg_state
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] busy_cnt, busy_cnt_nxt;
    logic [CW-1:0] starve_cnt, starve_cnt_nxt;
    logic          mem_en_q, mem_en_nxt;
    logic          mem_we_q, mem_we_nxt;
    logic [3:0]    mem_be_q, mem_be_nxt;
    logic [31:0]   mem_addr_q, mem_addr_nxt;
    logic [31:0]   mem_wdata_q, mem_wdata_nxt;
    logic [31:0]   i_rdata_q, i_rdata_nxt;
    logic [31:0]   d_rdata_q, d_rdata_nxt;
    logic          i_ack_q, i_ack_nxt;
    logic          d_ack_q, d_ack_nxt;
    logic          grant_d_q, grant_d_nxt;
    logic          take_i;
    logic          starve_full;

    assign starve_full = (starve_cnt == CW'(STARVE_MAX));

    always_comb begin
        state_nxt      = state;
        busy_cnt_nxt   = busy_cnt;
        starve_cnt_nxt = starve_cnt;
        mem_en_nxt     = mem_en_q;
        mem_we_nxt     = mem_we_q;
        mem_be_nxt     = mem_be_q;
        mem_addr_nxt   = mem_addr_q;
        mem_wdata_nxt  = mem_wdata_q;
        i_rdata_nxt    = i_rdata_q;
        d_rdata_nxt    = d_rdata_q;
        i_ack_nxt      = 1'b0;
        d_ack_nxt      = 1'b0;
        grant_d_nxt    = grant_d_q;
        take_i         = 1'b0;

        case (state)
            IDLE: begin
                // A waiting I is only counted as starved for as long as it keeps
                // asking.
                if (!bus.i_req) begin
                    starve_cnt_nxt = '0;
                end
                if (bus.i_req || bus.d_req) begin
                    take_i       = bus.i_req && (!bus.d_req || starve_full);
                    state_nxt    = BUSY;
                    mem_en_nxt   = 1'b1;
                    busy_cnt_nxt = CW'(LAT - 1);
                    if (take_i) begin
                        // Fetches are always full-word reads.
                        mem_we_nxt     = 1'b0;
                        mem_be_nxt     = 4'hF;
                        mem_addr_nxt   = bus.i_addr;
                        mem_wdata_nxt  = '0;
                        grant_d_nxt    = 1'b0;
                        starve_cnt_nxt = '0;
                    end else begin
                        mem_we_nxt    = bus.d_we;
                        mem_be_nxt    = bus.d_be;
                        mem_addr_nxt  = bus.d_addr;
                        mem_wdata_nxt = bus.d_wdata;
                        grant_d_nxt   = 1'b1;
                        if (bus.i_req && !starve_full) begin
                            starve_cnt_nxt = starve_cnt + CW'(1);
                        end
                    end
                end
            end
            BUSY: begin
                if (busy_cnt == '0) begin
                    // Last memory cycle. mem_rdata is valid now. D writes leave
                    // d_rdata alone.
                    if (!grant_d_q) begin
                        i_rdata_nxt = bus.mem_rdata;
                        i_ack_nxt   = 1'b1;
                    end else begin
                        if (!mem_we_q) begin
                            d_rdata_nxt = bus.mem_rdata;
                        end
                        d_ack_nxt = 1'b1;
                    end
                    mem_en_nxt = 1'b0;
                    mem_we_nxt = 1'b0;
                    state_nxt  = DONE;
                end else begin
                    busy_cnt_nxt = busy_cnt - CW'(1);
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            busy_cnt    <= '0;
            starve_cnt  <= '0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_be_q    <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            i_rdata_q   <= '0;
            d_rdata_q   <= '0;
            i_ack_q     <= 1'b0;
            d_ack_q     <= 1'b0;
            grant_d_q   <= 1'b0;
        end else begin
            state       <= state_nxt;
            busy_cnt    <= busy_cnt_nxt;
            starve_cnt  <= starve_cnt_nxt;
            mem_en_q    <= mem_en_nxt;
            mem_we_q    <= mem_we_nxt;
            mem_be_q    <= mem_be_nxt;
            mem_addr_q  <= mem_addr_nxt;
            mem_wdata_q <= mem_wdata_nxt;
            i_rdata_q   <= i_rdata_nxt;
            d_rdata_q   <= d_rdata_nxt;
            i_ack_q     <= i_ack_nxt;
            d_ack_q     <= d_ack_nxt;
            grant_d_q   <= grant_d_nxt;
        end
    end

    assign bus.mem_en    = mem_en_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_be    = mem_be_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.i_rdata   = i_rdata_q;
    assign bus.d_rdata   = d_rdata_q;
    assign bus.i_ack     = i_ack_q;
    assign bus.d_ack     = d_ack_q;
    assign bus.grant_d   = grant_d_q;
    assign dbg_state     = state;
endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares one single-port unified memory between the fetch stage (I port) and the memory stage (D port).
- Sequences each access over a fixed number of memory cycles.
- Returns read data with a one-cycle ack pulse; the hazard unit holds the requesting stage until that pulse.
- Fixed priority to D, with an anti-starvation override for I.

Parameters:
- LAT, 2, memory access length in cycles (>=1); mem_en is held for exactly LAT cycles per access.
- STARVE_MAX, 4, consecutive D grants made while I was waiting before I is forced (>=1).
- CW, 3, width of the busy and starve counters; must hold max(LAT, STARVE_MAX).

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low; 0 = reset.
- i_req  in  1  fetch request; held with i_addr stable until i_ack.
- i_addr  in  32  fetch address.
- i_rdata  out  32  fetched word; valid in the i_ack cycle and held until the next i_ack.
- i_ack  out  1  one-cycle completion pulse for I.
- d_req  in  1  data request; held with d_we/d_be/d_addr/d_wdata stable until d_ack.
- d_we  in  1  1 = write.
- d_be  in  4  byte enables for writes.
- d_addr  in  32  data address.
- d_wdata  in  32  write data.
- d_rdata  out  32  load data; valid in the d_ack cycle of a read; unchanged by writes.
- d_ack  out  1  one-cycle completion pulse for D.
- mem_en  out  1  memory access active.
- mem_we  out  1  memory write strobe.
- mem_be  out  4  byte enables to memory.
- mem_addr  out  32  memory address.
- mem_wdata  out  32  memory write data.
- mem_rdata  in  32  memory read data; valid in the last cycle of an access.
- grant_d  out  1  1 while the current or last granted access belongs to D (status/debug).

Behaviour:
- States: IDLE, BUSY, DONE. All outputs are registered.
- Reset (reset=0, immediate, asynchronous):
  - state=IDLE; busy and starve counters=0.
  - mem_en, mem_we, i_ack, d_ack, grant_d = 0.
  - mem_be, mem_addr, mem_wdata, i_rdata, d_rdata = 0.
- IDLE arbitration (requests sampled on the clock edge):
  - Only d_req → grant D.
  - Only i_req → grant I.
  - Both → grant D, unless starve==STARVE_MAX, in which case grant I.
  - Neither → stay in IDLE.
- On a grant: next state=BUSY; latch the winner's address/we/be/wdata into the mem_* registers; mem_en=1; mem_we=d_we for D, 0 for I; grant_d=1 for D, 0 for I; busy counter=LAT-1.
- BUSY:
  - mem_* outputs held constant.
  - Counter decrements each cycle.
  - In the cycle the counter reads 0: capture mem_rdata into the winner's rdata register (I always; D only when the access is a read); clear mem_en and mem_we; go to DONE.
  - mem_en is therefore high for exactly LAT cycles.
- DONE: winner's ack=1 for exactly this cycle; next state=IDLE; the loser's rdata register is never modified.
- Access period: a request seen in IDLE at edge T produces its ack during cycle T+LAT+1; back-to-back accesses cost LAT+2 cycles each.
- Starve counter:
  - Increments, saturating at STARVE_MAX, on each D grant made while i_req=1.
  - Clears on any I grant, or in IDLE when i_req=0.
- A requester may keep req high after its ack to issue a new request; it is re-arbitrated in the IDLE cycle after DONE.
- Dropping req during BUSY is a protocol violation; the access still completes and is acked.
- Reset asserted in BUSY or DONE aborts the access: no ack is ever issued for it, and no rdata is updated.
- i_ack and d_ack are never high in the same cycle.

Test Plan:
- Reset: hold reset=0 with random inputs for 3 cycles → every output is 0; after release with no requests, mem_en stays 0.
- Single fetch: i_req=1, i_addr=0x00003000, memory returns 0x24080001 (LAT=2) → mem_en=1 and mem_addr=0x3000 for exactly 2 cycles; i_ack pulses once, 3 cycles after the grant edge; i_rdata=0x24080001; d_ack stays 0.
- Simultaneous requests: i_req and d_req rise together, d_addr=0x10, d_we=0, mem returns 0xAAAA0000 then 0x12345678 → D served first (d_rdata=0xAAAA0000); I acked 4 cycles after d_ack (i_rdata=0x12345678).
- Starvation: d_req and i_req held high continuously → grant order D,D,D,D,I,D…; the fifth grant goes to I; starve returns to 0 after it.
- Write: d_we=1, d_be=4'b0011, d_addr=0x00000004, d_wdata=0xDEADBEEF → mem_we=1 only during the 2 BUSY cycles with those values on mem_*; d_ack pulses; d_rdata keeps its prior value.
- Reset mid-access: assert reset=0 in the first BUSY cycle → mem_en falls with no clock edge; after release, no ack appears for the aborted request; a re-issued request completes normally.
